// File: rtl/array_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : array_lane_ctrl
// Purpose  : Access controller for a 1R1W synchronous masked-write array
//            (DEPTH entries x LANES lanes x LANE_W bits). It shares the single
//            read port among NREQ requesters with round-robin arbitration,
//            passes one write requester straight to the write port, and
//            captures read data so a stalled response stays stable.
// Optional : `define ARRAY_LANE_CTRL_SCRUB_EN to zero every array entry after
//            reset, before any traffic is accepted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset                    single clock, async active-high reset
//   wr_valid/wr_ready               write request handshake
//   wr_addr/wr_data/wr_mask         write address, data, per-lane enable
//   rd_req_valid/rd_req_ready       per-requester read request / one-hot grant
//   rd_req_addr                     requester i at [i*ADDR_W +: ADDR_W]
//   rd_resp_valid/rd_resp_ready     read response handshake
//   rd_resp_data/rd_resp_id         read data and granted requester index
//   init_done                       controller is accepting traffic
//   W0_en/W0_addr/W0_data/W0_mask   array write port
//   R0_en/R0_addr                   array read port request
//   R0_data                         array read data, valid cycle after R0_en
// ============================================================================
module array_lane_ctrl #(
    parameter  int NREQ   = 2,
    parameter  int DEPTH  = 64,
    parameter  int ADDR_W = 6,
    parameter  int LANES  = 16,
    parameter  int LANE_W = 19,
    localparam int DW     = LANES * LANE_W,
    localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    // write requester
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [LANES-1:0]         wr_mask,
    // read requesters
    input  logic [NREQ-1:0]          rd_req_valid,
    output logic [NREQ-1:0]          rd_req_ready,
    input  logic [NREQ*ADDR_W-1:0]   rd_req_addr,
    // read response
    output logic                     rd_resp_valid,
    input  logic                     rd_resp_ready,
    output logic [DW-1:0]            rd_resp_data,
    output logic [ID_W-1:0]          rd_resp_id,
    // status
    output logic                     init_done,
    // array write port
    output logic                     W0_en,
    output logic [ADDR_W-1:0]        W0_addr,
    output logic [DW-1:0]            W0_data,
    output logic [LANES-1:0]         W0_mask,
    // array read port
    output logic                     R0_en,
    output logic [ADDR_W-1:0]        R0_addr,
    input  logic [DW-1:0]            R0_data
);

    // Elaboration-time sanity check on the geometry.
    if ((NREQ < 1) || (DEPTH > (1 << ADDR_W))) begin : g_param_chk
        $error("array_lane_ctrl: NREQ must be >= 1 and DEPTH must fit in ADDR_W");
    end

    // ------------------------------------------------------------------------
    // Initialisation FSM (scrub) or permanent RUN
    // ------------------------------------------------------------------------
    logic                w_run;        // controller in RUN
    logic                w_scrub_wr;   // scrub write this cycle
    logic [ADDR_W-1:0]   w_scrub_addr; // scrub write address

`ifdef ARRAY_LANE_CTRL_SCRUB_EN
    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_scrub_addr;
    logic [ADDR_W-1:0]   w_scrub_addr_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_SCRUB;
            r_scrub_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_scrub_addr <= w_scrub_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_scrub_addr_nxt = r_scrub_addr;
        if (r_state == ST_SCRUB) begin
            if (r_scrub_addr == c_LAST_ADDR) begin
                w_state_nxt      = ST_RUN;
                w_scrub_addr_nxt = '0;
            end else begin
                w_scrub_addr_nxt = r_scrub_addr + ADDR_W'(1);
            end
        end
    end

    assign w_run        = (r_state == ST_RUN);
    // Reset is folded in so the write port stays quiet while reset is held.
    assign w_scrub_wr   = (r_state == ST_SCRUB) && !reset;
    assign w_scrub_addr = r_scrub_addr;
`else
    assign w_run        = 1'b1;
    assign w_scrub_wr   = 1'b0;
    assign w_scrub_addr = '0;
`endif

    // ------------------------------------------------------------------------
    // Read arbitration
    // ------------------------------------------------------------------------
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id_q;
    logic                r_resp_valid;
    logic                r_held;
    logic [DW-1:0]       r_hold_q;

    logic [NREQ-1:0]     w_ge;        // requester index >= rr pointer
    logic [NREQ-1:0]     w_hi;        // valid requesters at/after the pointer
    logic [NREQ-1:0]     w_pick;      // candidate set for lowest-index pick
    logic [NREQ-1:0]     w_onehot;    // winning requester
    logic [ID_W-1:0]     w_grant_idx;
    logic [ADDR_W-1:0]   w_grant_addr;
    logic [ID_W-1:0]     w_rr_nxt;
    logic                w_slot_free;
    logic                w_issue;

    always_comb begin
        w_ge = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ge[i] = (ID_W'(i) >= r_rr_ptr);
        end
    end

    // Round-robin as a two-pass priority pick: first valid requester at or
    // after the pointer, otherwise wrap to the lowest valid index.
    assign w_hi     = rd_req_valid & w_ge;
    assign w_pick   = (|w_hi) ? w_hi : rd_req_valid;
    assign w_onehot = w_pick & (~w_pick + NREQ'(1));

    always_comb begin
        w_grant_idx  = '0;
        w_grant_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_onehot[i]) begin
                w_grant_idx  = ID_W'(i);
                w_grant_addr = rd_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_rr_nxt    = (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
    // The single response slot is free when empty or being consumed now.
    assign w_slot_free = !r_resp_valid || rd_resp_ready;
    assign w_issue     = w_run && !reset && w_slot_free && (|rd_req_valid);

    // ------------------------------------------------------------------------
    // Response tracking and stall capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr     <= '0;
            r_id_q       <= '0;
            r_resp_valid <= 1'b0;
            r_held       <= 1'b0;
            r_hold_q     <= '0;
        end else begin
            if (w_issue) begin
                r_rr_ptr     <= w_rr_nxt;
                r_id_q       <= w_grant_idx;
                r_resp_valid <= 1'b1;
                r_held       <= 1'b0;
            end else if (r_resp_valid && rd_resp_ready) begin
                r_resp_valid <= 1'b0;
                r_held       <= 1'b0;
            end else if (r_resp_valid && !r_held) begin
                // First response cycle went unconsumed: freeze the array
                // output so later writes to the same entry cannot leak in.
                r_held   <= 1'b1;
                r_hold_q <= R0_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------------
    always_comb begin
        W0_en        = 1'b0;
        W0_addr      = wr_addr;
        W0_data      = wr_data;
        W0_mask      = wr_mask;
        wr_ready     = 1'b0;
        rd_req_ready = '0;
        R0_en        = 1'b0;
        R0_addr      = w_grant_addr;

        if (w_scrub_wr) begin
            W0_en   = 1'b1;
            W0_addr = w_scrub_addr;
            W0_data = '0;
            W0_mask = '1;
        end else if (w_run && !reset) begin
            wr_ready = 1'b1;
            W0_en    = wr_valid;
        end

        if (w_issue) begin
            rd_req_ready = w_onehot;
            R0_en        = 1'b1;
        end
    end

    assign rd_resp_valid = r_resp_valid;
    assign rd_resp_id    = r_id_q;
    assign rd_resp_data  = !r_resp_valid ? '0 : (r_held ? r_hold_q : R0_data);
    assign init_done     = w_run;

endmodule
`default_nettype wire
